// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory/IO bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [AW-1:0] LEDADDR = 9'h100;
   localparam logic [AW-1:0] SWADDR  = 9'h140;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ACCESS   = 2'b01,
      ST_COMPLETE = 2'b10
   } state_e;

   typedef struct packed {
      logic [1:0]    cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   // Encoding 11 is deliberately not a request.
   function automatic logic is_req(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side and memory/IO-side signals of the arbiter, grouped as one bundle.
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   logic [1:0]    m0_cmd;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic [DW-1:0] m0_rdata;
   logic          m0_ready;
   logic [1:0]    m1_cmd;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [DW-1:0] m1_rdata;
   logic          m1_ready;
   logic [7:0]    ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_dout;
   logic [7:0]    sw;
   logic [7:0]    led;
   logic [1:0]    grant;

   modport slave (
      input  m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_dout, sw,
      output m0_rdata, m0_ready, m1_rdata, m1_ready, ram_addr, ram_we, ram_wdata, led, grant
   );

   modport master (
      output m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_dout, sw,
      input  m0_rdata, m0_ready, m1_rdata, m1_ready, ram_addr, ram_we, ram_wdata, led, grant
   );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker; last_q remembers who owned the bus last.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   output logic [1:0] gnt_c_o
);

   logic last_q;

   // On a tie the master that did not win last time goes first.
   always_comb begin
      gnt_c_o = req_i;
      if (req_i == 2'b11) gnt_c_o = last_q ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  last_q <= 1'b1;
      else if (upd_i && |gnt_c_o)  last_q <= gnt_c_o[1];
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM and the LED/switch I/O between two masters using fixed
// IDLE -> ACCESS -> COMPLETE transactions.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   mem_bus_arbiter_if.slave  bus
);

   state_e        state_q;
   req_t          lat_q;
   logic [1:0]    grant_q;
   logic [1:0]    ready_q;
   logic          ram_we_q;
   logic [7:0]    led_q;
   logic [DW-1:0] m0_rdata_q;
   logic [DW-1:0] m1_rdata_q;

   logic [1:0]    req_c;
   logic [1:0]    win_c;
   req_t          pick_c;
   logic [DW-1:0] rdata_c;

   assign req_c = {is_req(bus.m1_cmd), is_req(bus.m0_cmd)};

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (reset_n),
      .req_i   (req_c),
      .upd_i   (state_q == ST_IDLE),
      .gnt_c_o (win_c)
   );

   always_comb begin
      pick_c = '{cmd: bus.m0_cmd, addr: bus.m0_addr, wdata: bus.m0_wdata};
      if (win_c[1]) pick_c = '{cmd: bus.m1_cmd, addr: bus.m1_addr, wdata: bus.m1_wdata};
   end

   // RAM data only arrives in COMPLETE, so the read path is muxed live there.
   always_comb begin
      rdata_c = '0;
      if (lat_q.cmd == MREAD) begin
         if (!lat_q.addr[AW-1])          rdata_c = bus.ram_dout;
         else if (lat_q.addr == SWADDR)  rdata_c = {8'h00, bus.sw};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         lat_q      <= '0;
         grant_q    <= '0;
         ready_q    <= '0;
         ram_we_q   <= 1'b0;
         led_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|win_c) begin
                  lat_q    <= pick_c;
                  grant_q  <= win_c;
                  ram_we_q <= (pick_c.cmd == MWRITE) && !pick_c.addr[AW-1];
                  state_q  <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               ram_we_q <= 1'b0;
               if (lat_q.cmd == MWRITE && lat_q.addr == LEDADDR) led_q <= lat_q.wdata[7:0];
               ready_q  <= grant_q;
               state_q  <= ST_COMPLETE;
            end
            ST_COMPLETE: begin
               if (grant_q[0]) m0_rdata_q <= rdata_c;
               if (grant_q[1]) m1_rdata_q <= rdata_c;
               ready_q <= '0;
               grant_q <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.ram_addr  = lat_q.addr[7:0];
   assign bus.ram_wdata = lat_q.wdata;
   assign bus.ram_we    = ram_we_q;
   assign bus.led       = led_q;
   assign bus.grant     = grant_q;
   assign bus.m0_ready  = ready_q[0];
   assign bus.m1_ready  = ready_q[1];
   assign bus.m0_rdata  = (state_q == ST_COMPLETE && grant_q[0]) ? rdata_c : m0_rdata_q;
   assign bus.m1_rdata  = (state_q == ST_COMPLETE && grant_q[1]) ? rdata_c : m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a queued scoreboard of ready responses.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic clk;
   logic reset_n;
   mem_bus_arbiter_if bus();

   mem_bus_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   typedef struct {
      int          m;
      logic [15:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   int          total_cnt = 0;
   int          pass_cnt  = 0;
   logic [15:0] mem [256];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous RAM: data for the address shows up one cycle later.
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_dout <= mem[bus.ram_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Scoreboard monitor: every ready pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (reset_n && (bus.m0_ready || bus.m1_ready)) begin
         chk("ready one-hot", {30'd0, bus.m1_ready, bus.m0_ready} == 2 || {30'd0, bus.m1_ready, bus.m0_ready} == 1, 1);
         if (exp_q.size() == 0) begin
            chk("unexpected ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready master", bus.m1_ready ? 1 : 0, 32'(e.m));
            chk("grant at ready", {30'd0, bus.grant}, (e.m == 1) ? 2 : 1);
            chk("rdata", bus.m1_ready ? {16'd0, bus.m1_rdata} : {16'd0, bus.m0_rdata}, {16'd0, e.rdata});
         end
      end
   end

   // Drive one request, wait for its ready, drop cmd in the ready cycle.
   // exp_we: -1 skip, 0 expect no RAM write, N expect ram_we only in cycle N.
   task automatic txn(input int m, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] wd, input int exp_lat, input int exp_we, input string nm);
      int cyc = 0;
      int we_cyc = 0;
      int we_n = 0;
      logic got = 1'b0;
      logic [7:0] we_addr = '0;
      logic [15:0] we_data = '0;
      if (m == 0) begin bus.m0_cmd = cmd; bus.m0_addr = addr; bus.m0_wdata = wd; end
      else        begin bus.m1_cmd = cmd; bus.m1_addr = addr; bus.m1_wdata = wd; end
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ram_we) begin we_n++; we_cyc = cyc; we_addr = bus.ram_addr; we_data = bus.ram_wdata; end
         got = (m == 0) ? bus.m0_ready : bus.m1_ready;
      end
      if (m == 0) bus.m0_cmd = MNONE;
      else        bus.m1_cmd = MNONE;
      chk({nm, " ready seen"}, {31'd0, got}, 1);
      if (exp_lat > 0) chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
      if (exp_we == 0) chk({nm, " no ram_we"}, 32'(we_n), 0);
      if (exp_we > 0) begin
         chk({nm, " ram_we count"}, 32'(we_n), 1);
         chk({nm, " ram_we cycle"}, 32'(we_cyc), 32'(exp_we));
         chk({nm, " ram_addr"}, {24'd0, we_addr}, {24'd0, addr[7:0]});
         chk({nm, " ram_wdata"}, {16'd0, we_data}, {16'd0, wd});
      end
   endtask

   task automatic push(input int m, input logic [15:0] rd);
      exp_t e;
      e.m = m;
      e.rdata = rd;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      bus.m0_cmd = MNONE; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_cmd = MNONE; bus.m1_addr = '0; bus.m1_wdata = '0;
      bus.sw = 8'h5C;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset grant", {30'd0, bus.grant}, 0);
      chk("reset led", {24'd0, bus.led}, 0);
      chk("reset ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
      chk("reset rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
      chk("reset ram_we", {31'd0, bus.ram_we}, 0);
      chk("reset ram_addr", {24'd0, bus.ram_addr}, 0);

      // RAM write then read-back by master 0.
      push(0, 16'h0000);
      @(posedge clk); #1; txn(0, MWRITE, 9'h010, 16'h00A5, 3, 2, "m0 wr ram");
      chk("led after ram write", {24'd0, bus.led}, 0);
      push(0, 16'h00A5);
      @(posedge clk); #1; txn(0, MREAD, 9'h010, 16'h0000, 3, 0, "m0 rd ram");

      // LED write and switch read by master 1.
      push(1, 16'h0000);
      @(posedge clk); #1; txn(1, MWRITE, 9'h100, 16'h1234, 3, 0, "m1 wr led");
      chk("led loaded", {24'd0, bus.led}, 32'h34);
      push(1, 16'h005C);
      @(posedge clk); #1; txn(1, MREAD, 9'h140, 16'h0000, 3, 0, "m1 rd sw");
      chk("led after read", {24'd0, bus.led}, 32'h34);

      // Unmapped I/O and switch-port write are discarded.
      push(1, 16'h0000);
      @(posedge clk); #1; txn(1, MWRITE, 9'h1FF, 16'hABCD, 3, 0, "m1 wr unmapped");
      push(1, 16'h0000);
      @(posedge clk); #1; txn(1, MREAD, 9'h1FF, 16'h0000, 3, 0, "m1 rd unmapped");
      push(1, 16'h0000);
      @(posedge clk); #1; txn(1, MWRITE, 9'h140, 16'h00EE, 3, 0, "m1 wr sw");
      chk("led after discards", {24'd0, bus.led}, 32'h34);

      // Four simultaneous-request rounds: m0 wins each, m1 reads what m0 wrote.
      for (int r = 0; r < 4; r++) begin
         push(0, 16'h0000);
         push(1, 16'h0100 + 16'(r));
         @(posedge clk); #1;
         fork
            txn(0, MWRITE, 9'h030 + 9'(r), 16'h0100 + 16'(r), 3, -1, "tie m0");
            txn(1, MREAD,  9'h030 + 9'(r), 16'h0000,          6, -1, "tie m1");
         join
      end

      // Reset during ACCESS of an LED write aborts it.
      @(posedge clk); #1;
      bus.m0_cmd = MWRITE; bus.m0_addr = 9'h100; bus.m0_wdata = 16'h00FF;
      @(negedge clk);
      @(negedge clk);
      chk("abort grant in access", {30'd0, bus.grant}, 1);
      reset_n = 1'b0;
      #1;
      bus.m0_cmd = MNONE;
      chk("abort grant", {30'd0, bus.grant}, 0);
      chk("abort led", {24'd0, bus.led}, 0);
      chk("abort ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("led after abort", {24'd0, bus.led}, 0);
      chk("grant idle after abort", {30'd0, bus.grant}, 0);

      // First tie after reset goes to m0.
      push(0, 16'h0100);
      push(1, 16'h0103);
      @(posedge clk); #1;
      fork
         txn(0, MREAD, 9'h030, 16'h0000, 3, 0, "post-reset tie m0");
         txn(1, MREAD, 9'h033, 16'h0000, 6, 0, "post-reset tie m1");
      join

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      chk("scoreboard drained", 32'(exp_q.size()), 0);
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
